// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared between the ALU and its operand sequencer front-end:
// the sequencer FSM state encoding, the ALU operation codes, and a helper
// that maps a sequencer state to its one-hot progress LEDs.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Sequencer state encoding.
  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SHOW    = 3'd4;

  typedef enum logic [2:0] {
    ST_LOAD_A  = LOAD_A,
    ST_LOAD_B  = LOAD_B,
    ST_LOAD_OP = LOAD_OP,
    ST_EXEC    = EXEC,
    ST_SHOW    = SHOW
  } seqStateT;

  // ALU operation codes (driven onto swSelect).
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_HALF = 2'b11;

  // One LED per operand-entry step; EXEC and SHOW light nothing.
  function automatic logic [2:0] stateLedFor(input seqStateT s);
    case (s)
      ST_LOAD_A:  return 3'b001;
      ST_LOAD_B:  return 3'b010;
      ST_LOAD_OP: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stability counter and registered rising-edge pulse
// for one raw push button. The debounced level only changes after
// DEBOUNCE_CYCLES consecutive synchronised samples that disagree with it.
// CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset (released level)
//   btnRaw     in   raw asynchronous button input
//   pressPulse out  one-cycle pulse on each debounced press
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnRaw,
  output logic pressPulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncQ1;
  logic             syncQ2;
  logic             debLevel;
  logic [CNT_W-1:0] stableCnt;

  // NOTE: every register here is written with <= so all flops sample the
  // values from before the edge; blocking assignments would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syncQ1     <= 1'b0;
      syncQ2     <= 1'b0;
      debLevel   <= 1'b0;
      stableCnt  <= '0;
      pressPulse <= 1'b0;
    end else begin
      syncQ1     <= btnRaw;
      syncQ2     <= syncQ1;
      pressPulse <= 1'b0;
      if (syncQ2 != debLevel) begin
        if (stableCnt == CNT_LAST) begin
          debLevel   <= syncQ2;
          stableCnt  <= '0;
          // Pulse only on the press direction, never on release.
          pressPulse <= syncQ2;
        end else begin
          stableCnt <= stableCnt + CNT_W'(1);
        end
      end else begin
        // Any sample agreeing with the debounced level restarts the count,
        // which is what rejects glitches and chatter.
        stableCnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
// Operand-entry front-end for the ALU. Each debounced press of btnEnter
// steps LOAD_A -> LOAD_B -> LOAD_OP -> EXEC -> SHOW -> LOAD_A, capturing
// sw into a, sw into b, swSel into swSelect, and finally the ALU result into
// q. btnClr returns to LOAD_A and clears all operands and the result; it wins
// over a simultaneous enter press.
//
// Ports
//   clk, rst_n   clock and synchronous active-low reset
//   sw[2:0]      data switches (operand A or B)
//   swSel[1:0]   operation switches
//   btnEnter     raw advance button
//   btnClr       raw clear button
//   aluQ[3:0]    combinational ALU result
//   a, b         registered operands to the ALU
//   swSelect     registered operation to the ALU
//   opValid      high during the single EXEC cycle
//   q            captured result
//   resultValid  q holds a fresh result
//   stateLed     one-hot LOAD_A/LOAD_B/LOAD_OP indicator
// -----------------------------------------------------------------------------
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic [1:0] swSel,
  input  logic       btnEnter,
  input  logic       btnClr,
  input  logic [3:0] aluQ,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [1:0] swSelect,
  output logic       opValid,
  output logic [3:0] q,
  output logic       resultValid,
  output logic [2:0] stateLed
);

  logic enterPulse;
  logic clrPulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) uEnterDebounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnRaw     (btnEnter),
    .pressPulse (enterPulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) uClrDebounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnRaw     (btnClr),
    .pressPulse (clrPulse)
  );

  seqStateT state;
  seqStateT nextState;
  logic     capA;
  logic     capB;
  logic     capOp;
  logic     capQ;
  logic     clrAll;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_LOAD_A;
    else        state <= nextState;
  end

  // NOTE: every signal is given a default before the case statement so no
  // path leaves it unassigned; otherwise synthesis would infer latches.
  always_comb begin
    nextState = state;
    capA      = 1'b0;
    capB      = 1'b0;
    capOp     = 1'b0;
    capQ      = 1'b0;
    clrAll    = 1'b0;
    opValid   = (state == ST_EXEC);
    stateLed  = stateLedFor(state);

    if (clrPulse) begin
      nextState = ST_LOAD_A;
      clrAll    = 1'b1;
    end else begin
      case (state)
        ST_LOAD_A: if (enterPulse) begin
          capA      = 1'b1;
          nextState = ST_LOAD_B;
        end
        ST_LOAD_B: if (enterPulse) begin
          capB      = 1'b1;
          nextState = ST_LOAD_OP;
        end
        ST_LOAD_OP: if (enterPulse) begin
          capOp     = 1'b1;
          nextState = ST_EXEC;
        end
        // Single cycle regardless of enter; the ALU inputs have been stable
        // since the LOAD_OP edge, so aluQ is settled here.
        ST_EXEC: begin
          capQ      = 1'b1;
          nextState = ST_SHOW;
        end
        ST_SHOW: if (enterPulse) nextState = ST_LOAD_A;
        default: nextState = ST_LOAD_A;
      endcase
    end
  end

  // Operand and result registers change only on the capture strobes.
  always_ff @(posedge clk) begin
    if (!rst_n || clrAll) begin
      a           <= '0;
      b           <= '0;
      swSelect    <= '0;
      q           <= '0;
      resultValid <= 1'b0;
    end else begin
      if (capA) begin
        a           <= sw;
        resultValid <= 1'b0;
      end
      if (capB)  b        <= sw;
      if (capOp) swSelect <= swSel;
      if (capQ) begin
        q           <= aluQ;
        resultValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_sequencer
// Directed bench. A behavioural ALU closes the loop on a/b/swSelect -> aluQ.
// Each operation sequence pushes its expected record into a scoreboard queue;
// a monitor pops it when opValid appears and checks the operands, then the
// captured result one cycle later.
// -----------------------------------------------------------------------------
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic [1:0] swSel;
  logic       btnEnter;
  logic       btnClr;
  logic [3:0] aluQ;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] swSelect;
  logic       opValid;
  logic [3:0] q;
  logic       resultValid;
  logic [2:0] stateLed;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .swSel       (swSel),
    .btnEnter    (btnEnter),
    .btnClr      (btnClr),
    .aluQ        (aluQ),
    .a           (a),
    .b           (b),
    .swSelect    (swSelect),
    .opValid     (opValid),
    .q           (q),
    .resultValid (resultValid),
    .stateLed    (stateLed)
  );

  // Reference ALU.
  always_comb begin
    case (swSelect)
      OP_ADD:  aluQ = {1'b0, a} + {1'b0, b};
      OP_SUB:  aluQ = {1'b0, a} - {1'b0, b};
      OP_EQ:   aluQ = {3'b000, a == b};
      default: aluQ = {2'b00, a[2:1]};
    endcase
  end

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] sel;
    logic [3:0] q;
    bit         abort;
  } expT;

  expT sbQ[$];
  int  nChecks = 0;
  int  nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (opValid === 1'b1) begin
        if (sbQ.size() == 0) begin
          check("unexpected_exec", sbQ.size(), 1);
        end else begin
          e = sbQ.pop_front();
          check("exec_a", a, e.a);
          check("exec_b", b, e.b);
          check("exec_sel", swSelect, e.sel);
          @(negedge clk);
          check("opvalid_one_cycle", opValid, 0);
          if (e.abort) begin
            check("abort_q", q, 0);
            check("abort_rv", resultValid, 0);
            check("abort_led", stateLed, 3'b001);
          end else begin
            check("show_q", q, e.q);
            check("show_rv", resultValid, 1);
            check("show_led", stateLed, 3'b000);
          end
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pressEnter();
    @(posedge clk); #1 btnEnter = 1'b1;
    waitCycles(DEB + 4);
    btnEnter = 1'b0;
    waitCycles(DEB + 8);
  endtask

  task automatic pressClr();
    @(posedge clk); #1 btnClr = 1'b1;
    waitCycles(DEB + 4);
    btnClr = 1'b0;
    waitCycles(DEB + 8);
  endtask

  task automatic doOp(input logic [2:0] opA, input logic [2:0] opB,
                      input logic [1:0] sel, input logic [3:0] expQ);
    expT e;
    sw = opA;  pressEnter();
    sw = opB;  pressEnter();
    swSel = sel;
    e.a = opA; e.b = opB; e.sel = sel; e.q = expQ; e.abort = 1'b0;
    sbQ.push_back(e);
    pressEnter();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    expT e;
    bit  found;
    rst_n = 1'b0; sw = '0; swSel = '0; btnEnter = 1'b0; btnClr = 1'b0;

    // Reset state.
    waitCycles(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_sel", swSelect, 0);
    check("rst_q", q, 0);
    check("rst_rv", resultValid, 0);
    check("rst_led", stateLed, 3'b001);

    // Add 4 + 7.
    doOp(3'b100, 3'b111, OP_ADD, 4'b1011);
    // Switch movement in SHOW must not disturb anything.
    sw = 3'b010; swSel = 2'b11;
    waitCycles(3);
    check("show_hold_a", a, 3'b100);
    check("show_hold_b", b, 3'b111);
    check("show_hold_sel", swSelect, OP_ADD);
    check("show_hold_q", q, 4'b1011);

    // Subtract 4 - 1.
    pressEnter();
    check("back_to_load_a", stateLed, 3'b001);
    doOp(3'b100, 3'b001, OP_SUB, 4'd3);
    pressEnter();
    check("show_to_load_a_led", stateLed, 3'b001);
    check("show_to_load_a_q", q, 4'd3);
    check("show_to_load_a_rv", resultValid, 1);
    sw = 3'b101;
    pressEnter();
    check("capA_led", stateLed, 3'b010);
    check("capA_a", a, 3'b101);
    check("capA_rv_drop", resultValid, 0);

    // Glitch shorter than DEB samples, in LOAD_B.
    @(posedge clk); #1 btnEnter = 1'b1;
    waitCycles(DEB - 2);
    btnEnter = 1'b0;
    waitCycles(DEB + 8);
    check("glitch_led", stateLed, 3'b010);
    // Chatter: toggle every cycle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      btnEnter = ~btnEnter;
      waitCycles(1);
    end
    btnEnter = 1'b0;
    waitCycles(DEB + 8);
    check("chatter_led", stateLed, 3'b010);
    check("chatter_b", b, 3'b001);

    // Clear back to LOAD_A, then a held button advances exactly once.
    pressClr();
    check("clr_led", stateLed, 3'b001);
    check("clr_a", a, 0);
    check("clr_q", q, 0);
    sw = 3'b110;
    @(posedge clk); #1 btnEnter = 1'b1;
    waitCycles(50);
    btnEnter = 1'b0;
    waitCycles(DEB + 8);
    check("held_led", stateLed, 3'b010);
    check("held_a", a, 3'b110);

    // Clear in LOAD_OP after A=3, B=1.
    pressClr();
    sw = 3'b011; pressEnter();
    sw = 3'b001; pressEnter();
    check("loadop_led", stateLed, 3'b100);
    check("loadop_a", a, 3'b011);
    check("loadop_b", b, 3'b001);
    pressClr();
    check("clr_loadop_led", stateLed, 3'b001);
    check("clr_loadop_a", a, 0);
    check("clr_loadop_b", b, 0);
    check("clr_loadop_q", q, 0);

    // Clear and enter in the same cycle: clear wins.
    sw = 3'b010; pressEnter();
    check("pre_both_led", stateLed, 3'b010);
    @(posedge clk); #1 btnEnter = 1'b1; btnClr = 1'b1;
    waitCycles(DEB + 4);
    btnEnter = 1'b0; btnClr = 1'b0;
    waitCycles(DEB + 8);
    check("both_led", stateLed, 3'b001);
    check("both_a", a, 0);

    // Reset during EXEC: the result is never captured.
    sw = 3'b110; pressEnter();
    sw = 3'b001; pressEnter();
    swSel = OP_ADD;
    e.a = 3'b110; e.b = 3'b001; e.sel = OP_ADD; e.q = 4'd0; e.abort = 1'b1;
    sbQ.push_back(e);
    found = 1'b0;
    @(posedge clk); #1 btnEnter = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (opValid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    btnEnter = 1'b0;
    check("exec_reached", found, 1);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(DEB + 8);
    check("post_rst_led", stateLed, 3'b001);
    check("post_rst_q", q, 0);
    check("post_rst_a", a, 0);

    waitCycles(3);
    check("scoreboard_drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
